// File: rtl/ren_pkg.sv
// Shared types and constants for the ren_* rasterizer front end.
// Fixed-point values are Q16.6 in a 22-bit signed word.
package ren_pkg;

   localparam int unsigned FP22_W    = 22;
   localparam int unsigned FP22_FRAC = 6;
   localparam int unsigned TILE_SIZE = 16;

   typedef logic signed [FP22_W-1:0] fp22_t;

   typedef struct packed {
      fp22_t a;
      fp22_t b;
      fp22_t c;
   } edge_t;

   typedef struct packed {
      fp22_t x;
      fp22_t y;
   } tile_t;

   typedef enum logic {
      SRC_R = 1'b0,
      SRC_S = 1'b1
   } src_e;

   function automatic fp22_t fp22_from_int(input int v);
      return fp22_t'(v <<< FP22_FRAC);
   endfunction

endpackage

// File: rtl/ren_tile_fifo.sv
// Single-clock flop FIFO with asynchronous head read; one instance per tile class.
// Pushes while full and pops while empty are ignored; flush clears count and pointers.
module ren_tile_fifo
   import ren_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  tile_t                  din,
   output tile_t                  dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   tile_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   // NOTE: storage is not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ren_tile_queue.sv
// Dual tile queue: partial (R) and full-cover (S) FIFOs merged round-robin
// into one registered valid/ready stream tagged with the source class.
module ren_tile_queue
   import ren_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic  clk,
   input  logic  rstn,
   input  logic  i_flush,
   input  logic  i_write_r,
   input  logic  i_write_s,
   input  tile_t i_tile,
   output logic  o_full_r,
   output logic  o_full_s,
   output logic  o_valid,
   input  logic  i_ready,
   output tile_t o_tile,
   output logic  o_full_cover,
   output logic  o_busy,
   output logic  o_overflow
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   tile_t         head_r, head_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          full_r, full_s, empty_r, empty_s;
   logic          pop_r, pop_s, load, both_ne;
   src_e          sel;

   logic  valid_q, valid_d;
   tile_t tile_q, tile_d;
   src_e  src_q, src_d;
   src_e  rr_q, rr_d;
   logic  ovf_q, ovf_d;

   ren_tile_fifo #(.DEPTH(DEPTH)) u_fifo_r (
      .clk   (clk),
      .rstn  (rstn),
      .flush (i_flush),
      .push  (i_write_r),
      .pop   (pop_r),
      .din   (i_tile),
      .dout  (head_r),
      .count (cnt_r),
      .full  (full_r),
      .empty (empty_r)
   );

   ren_tile_fifo #(.DEPTH(DEPTH)) u_fifo_s (
      .clk   (clk),
      .rstn  (rstn),
      .flush (i_flush),
      .push  (i_write_s),
      .pop   (pop_s),
      .din   (i_tile),
      .dout  (head_s),
      .count (cnt_s),
      .full  (full_s),
      .empty (empty_s)
   );

   always_comb begin
      both_ne = !empty_r && !empty_s;
      load    = (!valid_q || i_ready) && (!empty_r || !empty_s);
      sel     = both_ne ? rr_q : (empty_r ? SRC_S : SRC_R);
      pop_r   = load && (sel == SRC_R);
      pop_s   = load && (sel == SRC_S);

      valid_d = valid_q;
      tile_d  = tile_q;
      src_d   = src_q;
      rr_d    = rr_q;
      // Full test uses the start-of-cycle flag, so a same-cycle pop cannot rescue the write.
      ovf_d   = ovf_q || (i_write_r && full_r) || (i_write_s && full_s);

      if (i_flush) begin
         valid_d = 1'b0;
         rr_d    = SRC_R;
         ovf_d   = ovf_q;
      end else if (load) begin
         valid_d = 1'b1;
         tile_d  = (sel == SRC_S) ? head_s : head_r;
         src_d   = sel;
         if (both_ne) rr_d = (rr_q == SRC_R) ? SRC_S : SRC_R;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         tile_q  <= '0;
         src_q   <= SRC_R;
         rr_q    <= SRC_R;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         tile_q  <= tile_d;
         src_q   <= src_d;
         rr_q    <= rr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_full_r     = full_r;
   assign o_full_s     = full_s;
   assign o_valid      = valid_q;
   assign o_tile       = tile_q;
   assign o_full_cover = (src_q == SRC_S);
   assign o_busy       = (cnt_r != '0) || (cnt_s != '0) || valid_q;
   assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_ren_tile_queue.sv
// Directed bench for ren_tile_queue: reset, latency, fill/overflow, round-robin,
// back-pressure with a per-class scoreboard, flush and asynchronous reset.
module tb_ren_tile_queue;
   import ren_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic  clk = 1'b0;
   logic  rstn;
   logic  i_flush, i_write_r, i_write_s, i_ready;
   tile_t i_tile, o_tile;
   logic  o_full_r, o_full_s, o_valid, o_full_cover, o_busy, o_overflow;

   int n_checks = 0;
   int n_errors = 0;

   tile_t exp_r[$];
   tile_t exp_s[$];

   always #5 clk = ~clk;

   ren_tile_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_flush      (i_flush),
      .i_write_r    (i_write_r),
      .i_write_s    (i_write_s),
      .i_tile       (i_tile),
      .o_full_r     (o_full_r),
      .o_full_s     (o_full_s),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_tile       (o_tile),
      .o_full_cover (o_full_cover),
      .o_busy       (o_busy),
      .o_overflow   (o_overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic tile_t mk(input int x, input int y);
      tile_t t;
      t.x = fp22_from_int(x);
      t.y = fp22_from_int(y);
      return t;
   endfunction

   function automatic logic [5:0] flags();
      return {o_valid, o_full_cover, o_full_r, o_full_s, o_busy, o_overflow};
   endfunction

   task automatic push(input logic wr, input logic ws, input tile_t t);
      i_write_r = wr;
      i_write_s = ws;
      i_tile    = t;
      step();
      i_write_r = 1'b0;
      i_write_s = 1'b0;
   endtask

   // Leaves tile t stalled in the output register so later pushes stay queued.
   task automatic park(input tile_t t);
      i_ready = 1'b0;
      push(1'b1, 1'b0, t);
      step();
   endtask

   task automatic sb_take();
      if (o_full_cover) begin
         check("bp_s_nonempty", 64'(exp_s.size() > 0), 64'(1));
         if (exp_s.size() > 0) check("bp_s_tile", 64'(o_tile), 64'(exp_s.pop_front()));
      end else begin
         check("bp_r_nonempty", 64'(exp_r.size() > 0), 64'(1));
         if (exp_r.size() > 0) check("bp_r_tile", 64'(o_tile), 64'(exp_r.pop_front()));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tile_t park_t;
      tile_t exp_t [7];
      logic  exp_fc [7];
      tile_t prev_tile;
      logic  prev_fc;
      logic  prev_stall;

      // Reset with random inputs
      rstn      = 1'b0;
      i_flush   = 1'($urandom);
      i_write_r = 1'($urandom);
      i_write_s = 1'($urandom);
      i_ready   = 1'($urandom);
      i_tile.x  = fp22_t'($urandom);
      i_tile.y  = fp22_t'($urandom);
      repeat (2) step();
      check("rst_flags", 64'(flags()), 64'(0));
      check("rst_tile", 64'(o_tile), 64'(0));

      i_flush = 1'b0; i_write_r = 1'b0; i_write_s = 1'b0; i_ready = 1'b0;
      i_tile  = '0;
      rstn    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_flags", 64'(flags()), 64'(0));
      end
      check("idle_tile", 64'(o_tile), 64'(0));

      // Single write, no stall: visible after the following edge, gone one cycle later
      i_ready = 1'b1;
      push(1'b1, 1'b0, mk(16, 32));
      check("sw_valid_early", 64'(o_valid), 64'(0));
      check("sw_busy_queued", 64'(o_busy), 64'(1));
      step();
      check("sw_valid", 64'(o_valid), 64'(1));
      check("sw_tile", 64'(o_tile), 64'(mk(16, 32)));
      check("sw_fc", 64'(o_full_cover), 64'(0));
      step();
      check("sw_valid_off", 64'(o_valid), 64'(0));
      check("sw_busy_off", 64'(o_busy), 64'(0));

      // Fill S while the output register is stalled, then overflow
      park_t = mk(999, 999);
      park(park_t);
      check("fill_parked", 64'(o_tile), 64'(park_t));
      check("fill_ovf_pre", 64'(o_overflow), 64'(0));
      for (int k = 0; k < 16; k++) begin
         push(1'b0, 1'b1, mk(k, 200 + k));
         check("fill_full_s", 64'(o_full_s), 64'(k == 15));
      end
      push(1'b0, 1'b1, mk(77, 77));
      check("ovf_set", 64'(o_overflow), 64'(1));
      check("ovf_full_s", 64'(o_full_s), 64'(1));
      i_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         check("drain_valid", 64'(o_valid), 64'(1));
         check("drain_tile", 64'(o_tile), 64'((i == 0) ? park_t : mk(i - 1, 200 + i - 1)));
         check("drain_fc", 64'(o_full_cover), 64'(i != 0));
         step();
      end
      check("drain_done_valid", 64'(o_valid), 64'(0));
      check("drain_done_busy", 64'(o_busy), 64'(0));
      check("drain_full_s", 64'(o_full_s), 64'(0));
      check("ovf_sticky", 64'(o_overflow), 64'(1));

      // Round-robin: A0..A2 in R, B0..B2 in S, behind a parked tile
      park(mk(500, 0));
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, mk(300 + i, 1));
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, mk(400 + i, 2));
      exp_t[0] = mk(500, 0); exp_fc[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_t[1 + 2*i] = mk(300 + i, 1); exp_fc[1 + 2*i] = 1'b0;
         exp_t[2 + 2*i] = mk(400 + i, 2); exp_fc[2 + 2*i] = 1'b1;
      end
      i_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         check("rr_valid", 64'(o_valid), 64'(1));
         check("rr_tile", 64'(o_tile), 64'(exp_t[i]));
         check("rr_fc", 64'(o_full_cover), 64'(exp_fc[i]));
         step();
      end
      check("rr_done", 64'(o_valid), 64'(0));

      // Back-pressure with mixed pushes and a per-class scoreboard
      prev_stall = 1'b0;
      prev_tile  = '0;
      prev_fc    = 1'b0;
      for (int n = 0; n < 200; n++) begin
         int cls;
         cls       = int'($urandom_range(0, 2));
         i_write_r = (cls != 1) && !o_full_r;
         i_write_s = (cls != 0) && !o_full_s;
         i_tile    = mk(1000 + n, cls);
         if (i_write_r) exp_r.push_back(i_tile);
         if (i_write_s) exp_s.push_back(i_tile);
         i_ready   = 1'($urandom);
         if (prev_stall) begin
            check("bp_stable_tile", 64'(o_tile), 64'(prev_tile));
            check("bp_stable_fc", 64'(o_full_cover), 64'(prev_fc));
         end
         if (o_valid && i_ready) sb_take();
         prev_stall = o_valid && !i_ready;
         prev_tile  = o_tile;
         prev_fc    = o_full_cover;
         step();
      end
      i_write_r = 1'b0;
      i_write_s = 1'b0;
      i_ready   = 1'b1;
      for (int c = 0; c < 100 && o_busy; c++) begin
         if (o_valid) sb_take();
         step();
      end
      check("bp_drained", 64'(o_busy), 64'(0));
      check("bp_r_left", 64'(exp_r.size()), 64'(0));
      check("bp_s_left", 64'(exp_s.size()), 64'(0));

      // Flush with 5 tiles queued; a same-cycle write must be discarded
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(1'b1, 1'b0, mk(600 + i, 3));
      check("fl_busy_pre", 64'(o_busy), 64'(1));
      check("fl_valid_pre", 64'(o_valid), 64'(1));
      i_flush   = 1'b1;
      i_write_s = 1'b1;
      i_tile    = mk(700, 0);
      step();
      i_flush   = 1'b0;
      i_write_s = 1'b0;
      check("fl_valid", 64'(o_valid), 64'(0));
      check("fl_busy", 64'(o_busy), 64'(0));
      check("fl_ovf_kept", 64'(o_overflow), 64'(1));
      i_ready = 1'b1;
      repeat (3) step();
      check("fl_stays_empty", 64'({o_valid, o_busy}), 64'(0));

      // Asynchronous reset in mid-cycle with 5 tiles queued
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(1'b0, 1'b1, mk(800 + i, 4));
      check("rm_busy_pre", 64'(o_busy), 64'(1));
      #2;
      rstn = 1'b0;
      #1;
      check("rm_flags", 64'(flags()), 64'(0));
      check("rm_tile", 64'(o_tile), 64'(0));
      #2;
      rstn    = 1'b1;
      i_ready = 1'b1;
      repeat (2) step();
      check("rm_after", 64'(flags()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
